// File: rtl/dmac_top_ahb.sv
// AHB-Lite slave register front-end of the DMA controller with a transfer-count engine.
// Build option: define DMAC_ERR_RESP_EN for two-cycle ERROR on unmapped accesses and ID writes.
module dmac_top_ahb #(
  parameter logic [31:0] ID_VALUE = 32'h444D_0001
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        s_hsel,
  input  logic [1:0]  s_htrans,
  input  logic        s_hwrite,
  input  logic [31:0] s_haddr,
  input  logic [3:0]  s_hprot,
  input  logic [31:0] s_hwdata,
  output logic [31:0] s_hrdata,
  output logic        s_hready,
  output logic [1:0]  s_hresp
);

  localparam logic [5:0] IDX_SRC    = 6'd0;
  localparam logic [5:0] IDX_DST    = 6'd1;
  localparam logic [5:0] IDX_XFER   = 6'd2;
  localparam logic [5:0] IDX_CTRL   = 6'd3;
  localparam logic [5:0] IDX_STATUS = 6'd4;
  localparam logic [5:0] IDX_ID     = 6'd5;

  logic [5:0]  idx_s;
  logic        accept_s;
  logic        err_s;
  logic        wr_en_s;
  logic        fwd_s;
  logic        start_s;
  logic        done_set_s;
  logic        done_clr_s;
  logic [31:0] rd_mux_s;
  logic [31:0] fwd_val_s;
  logic [31:0] rd_val_s;

  logic        dp_valid_r;
  logic        dp_write_r;
  logic [5:0]  dp_idx_r;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] xfer_cnt_r;
  logic [15:0] cnt_r;
  logic        ie_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hrdata_r;
  logic        hready_r;
  logic [1:0]  hresp_r;

  logic        unused_s;
  assign unused_s = ^{s_hprot, s_htrans[0], s_haddr[31:8], s_haddr[1:0]};

  assign idx_s    = s_haddr[7:2];
  assign accept_s = s_hsel & s_htrans[1] & hready_r;
`ifdef DMAC_ERR_RESP_EN
  assign err_s    = accept_s & ((idx_s > IDX_ID) | (s_hwrite & (idx_s == IDX_ID)));
`else
  assign err_s    = 1'b0;
`endif
  assign wr_en_s  = dp_valid_r & dp_write_r;
  assign fwd_s    = wr_en_s & (dp_idx_r == idx_s);
  assign start_s  = wr_en_s & (dp_idx_r == IDX_CTRL) & s_hwdata[0] & ~busy_r;

  // Read mux of the current register contents
  always_comb begin
    rd_mux_s = 32'h0;
    case (idx_s)
      IDX_SRC:    rd_mux_s = src_r;
      IDX_DST:    rd_mux_s = dst_r;
      IDX_XFER:   rd_mux_s = {16'h0, xfer_cnt_r};
      IDX_CTRL:   rd_mux_s = {30'h0, ie_r, 1'b0};
      IDX_STATUS: rd_mux_s = {30'h0, done_r, busy_r};
      IDX_ID:     rd_mux_s = ID_VALUE;
      default:    rd_mux_s = 32'h0;
    endcase
  end

  // Forwarded view of the write in flight, with the same masking the register applies
  always_comb begin
    fwd_val_s = 32'h0;
    case (idx_s)
      IDX_SRC:    fwd_val_s = s_hwdata;
      IDX_DST:    fwd_val_s = s_hwdata;
      IDX_XFER:   fwd_val_s = busy_r ? {16'h0, xfer_cnt_r} : {16'h0, s_hwdata[15:0]};
      IDX_CTRL:   fwd_val_s = {30'h0, s_hwdata[1], 1'b0};
      IDX_STATUS: fwd_val_s = {30'h0, done_r & ~s_hwdata[1], busy_r};
      IDX_ID:     fwd_val_s = ID_VALUE;
      default:    fwd_val_s = 32'h0;
    endcase
  end

  // Read data source select
  always_comb begin
    if (err_s) begin
      rd_val_s = 32'h0;
    end else if (fwd_s) begin
      rd_val_s = fwd_val_s;
    end else begin
      rd_val_s = rd_mux_s;
    end
  end

  // Address-phase capture into data-phase registers
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_idx_r   <= 6'd0;
    end else begin
      dp_valid_r <= accept_s & ~err_s;
      dp_write_r <= s_hwrite;
      dp_idx_r   <= idx_s;
    end
  end

  // Read data register, held until the next accepted read
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      hrdata_r <= 32'h0;
    end else if (accept_s & ~s_hwrite) begin
      hrdata_r <= rd_val_s;
    end
  end

  // Programming registers
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      src_r      <= 32'h0;
      dst_r      <= 32'h0;
      xfer_cnt_r <= 16'h0;
      ie_r       <= 1'b0;
    end else if (wr_en_s) begin
      case (dp_idx_r)
        IDX_SRC:  src_r <= s_hwdata;
        IDX_DST:  dst_r <= s_hwdata;
        IDX_XFER: if (!busy_r) xfer_cnt_r <= s_hwdata[15:0];
        IDX_CTRL: ie_r <= s_hwdata[1];
        default:  ;
      endcase
    end
  end

  assign done_set_s = (start_s & (xfer_cnt_r == 16'h0)) | (busy_r & (cnt_r == 16'd1));
  assign done_clr_s = wr_en_s & (dp_idx_r == IDX_STATUS) & s_hwdata[1];

  // Transfer-count engine; a zero count completes without ever going busy
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      busy_r <= 1'b0;
      cnt_r  <= 16'h0;
      done_r <= 1'b0;
    end else begin
      if (start_s) begin
        if (xfer_cnt_r != 16'h0) begin
          busy_r <= 1'b1;
          cnt_r  <= xfer_cnt_r;
        end
      end else if (busy_r) begin
        if (cnt_r == 16'd1) begin
          busy_r <= 1'b0;
          cnt_r  <= 16'h0;
        end else begin
          cnt_r  <= cnt_r - 16'd1;
        end
      end
      done_r <= done_set_s | (done_r & ~done_clr_s);
    end
  end

`ifdef DMAC_ERR_RESP_EN
  // Two-cycle ERROR: hready low with ERROR, then hready high with ERROR
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      hready_r <= 1'b1;
      hresp_r  <= 2'b00;
    end else if (err_s) begin
      hready_r <= 1'b0;
      hresp_r  <= 2'b01;
    end else if (!hready_r) begin
      hready_r <= 1'b1;
      hresp_r  <= 2'b01;
    end else begin
      hready_r <= 1'b1;
      hresp_r  <= 2'b00;
    end
  end
`else
  // Zero-wait OKAY responses only
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      hready_r <= 1'b1;
      hresp_r  <= 2'b00;
    end else begin
      hready_r <= 1'b1;
      hresp_r  <= 2'b00;
    end
  end
`endif

  assign s_hrdata = hrdata_r;
  assign s_hready = hready_r;
  assign s_hresp  = hresp_r;

endmodule

// File: tb/tb_dmac_top_ahb.sv
// Scoreboard bench for dmac_top_ahb: reads push expected data, a monitor pops and compares.
module tb_dmac_top_ahb;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        s_hsel;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [31:0] s_haddr;
  logic [3:0]  s_hprot;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready;
  logic [1:0]  s_hresp;

  always #5 hclk = ~hclk;

  dmac_top_ahb dut (
    .hclk     (hclk),
    .hrst_n   (hrst_n),
    .s_hsel   (s_hsel),
    .s_htrans (s_htrans),
    .s_hwrite (s_hwrite),
    .s_haddr  (s_haddr),
    .s_hprot  (s_hprot),
    .s_hwdata (s_hwdata),
    .s_hrdata (s_hrdata),
    .s_hready (s_hready),
    .s_hresp  (s_hresp)
  );

  localparam logic [31:0] ID_EXP = 32'h444D_0001;

  logic [31:0] exp_q [$];
  logic [31:0] last_exp = 32'h0;
  logic [31:0] pend_wdata;
  logic        rd_ph;
  logic        exp_hready;
  logic [1:0]  exp_hresp;
  logic        end_chk;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Track read data phases independently of the stimulus
  always @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) rd_ph <= 1'b0;
    else         rd_ph <= s_hsel & s_htrans[1] & s_hready & ~s_hwrite;
  end

  // Monitor: pop an expectation per read data phase, otherwise rdata must hold
  always @(negedge hclk) begin
    if (!hrst_n) begin
      last_exp = 32'h0;
    end else if (rd_ph) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %h with no read expected at %0t", s_hrdata, $time);
      end else begin
        last_exp = exp_q.pop_front();
      end
    end
    chk("rdata", s_hrdata, last_exp);
    chk("hready", {31'h0, s_hready}, {31'h0, exp_hready});
    chk("hresp", {30'h0, s_hresp}, {30'h0, exp_hresp});
    if (end_chk) chk("queue_empty", exp_q.size(), 32'd0);
  end

  task automatic bus(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    s_hsel   = sel;
    s_htrans = tr;
    s_hwrite = wr;
    s_haddr  = addr;
    s_hprot  = 4'h3;
    s_hwdata = pend_wdata;
    pend_wdata = wd;
    if (sel && tr[1] && !wr) exp_q.push_back(exp);
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    bus(1'b1, 2'b10, 1'b1, addr, wd, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(1'b1, 2'b10, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic idle();
    bus(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; pend_wdata = 32'h0; end_chk = 1'b0;
    exp_hready = 1'b1; exp_hresp = 2'b00;
    hrst_n = 1'b0; s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0;
    s_haddr = 32'h0; s_hprot = 4'h0; s_hwdata = 32'h0;
    repeat (3) @(posedge hclk);
    #1 hrst_n = 1'b1;
    idle();

    // reset values
    rd(32'h00, 32'h0); rd(32'h04, 32'h0); rd(32'h08, 32'h0);
    rd(32'h0C, 32'h0); rd(32'h10, 32'h0); rd(32'h14, ID_EXP);

    // basic write/read, forwarding and hold
    wr(32'h00, 32'h5A5A_5A5A); rd(32'h00, 32'h5A5A_5A5A); idle(); idle();
    wr(32'h04, 32'hFFFF_0000); rd(32'h04, 32'hFFFF_0000); rd(32'h00, 32'h5A5A_5A5A);

    // non-transfers: hsel low, IDLE and BUSY with hsel high
    bus(1'b0, 2'b10, 1'b1, 32'h00, 32'h1, 32'h0); idle(); rd(32'h00, 32'h5A5A_5A5A);
    bus(1'b1, 2'b00, 1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0);
    bus(1'b1, 2'b01, 1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0);
    idle(); rd(32'h00, 32'h5A5A_5A5A);
    bus(1'b1, 2'b11, 1'b0, 32'h04, 32'h0, 32'hFFFF_0000);

    // XFER_CNT masking with forwarding, then plain read
    wr(32'h08, 32'hABCD_1234); rd(32'h08, 32'h0000_1234); idle(); rd(32'h08, 32'h0000_1234);

    // engine: count 4 -> BUSY for 4 cycles then DONE
    wr(32'h08, 32'h4); wr(32'h0C, 32'h1);
    rd(32'h10, 32'h0); rd(32'h10, 32'h1); rd(32'h10, 32'h1);
    rd(32'h10, 32'h1); rd(32'h10, 32'h1); rd(32'h10, 32'h2);
    rd(32'h0C, 32'h0);
    wr(32'h10, 32'h2); rd(32'h10, 32'h0); idle(); rd(32'h10, 32'h0);

    // XFER_CNT write ignored while busy; DONE set wins over W1C on the same edge
    wr(32'h0C, 32'h3); wr(32'h08, 32'h55); rd(32'h08, 32'h4);
    rd(32'h10, 32'h1); wr(32'h10, 32'h2); rd(32'h10, 32'h1); rd(32'h10, 32'h2);
    rd(32'h0C, 32'h2); rd(32'h08, 32'h4);
    wr(32'h10, 32'h2); idle(); rd(32'h10, 32'h0);

    // zero count: DONE without BUSY
    wr(32'h08, 32'h0); wr(32'h0C, 32'h1); rd(32'h10, 32'h0); rd(32'h10, 32'h2);
    wr(32'h10, 32'h2); idle();

`ifndef DMAC_ERR_RESP_EN
    wr(32'h20, 32'hDEAD_BEEF); rd(32'h20, 32'h0); rd(32'h18, 32'h0);
    wr(32'h14, 32'h0); rd(32'h14, ID_EXP); idle(); rd(32'h00, 32'h5A5A_5A5A);
`else
    wr(32'h20, 32'hDEAD_BEEF);
    exp_hready = 1'b0; exp_hresp = 2'b01; idle();
    exp_hready = 1'b1; exp_hresp = 2'b01; idle();
    exp_hresp = 2'b00; idle();
    rd(32'h00, 32'h5A5A_5A5A); rd(32'h14, ID_EXP);
`endif

    // reset during a write data phase aborts it
    wr(32'h00, 32'h0000_0077);
    hrst_n = 1'b0;
    idle();
    hrst_n = 1'b1;
    rd(32'h00, 32'h0); rd(32'h04, 32'h0);
    idle(); idle();
    end_chk = 1'b1;
    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
